instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/instr_fetch_unit_prog_mem.sv | 19 +
 rtl/instr_fetch_unit.sv | 82 ++++++++
 tb/tb_instr_fetch_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// instr_fetch_unit_pkg: state encoding, widths and instruction fields shared with the control unit
package instr_fetch_unit_pkg;
    localparam int DEPTH_DEF = 16;
    localparam int IW_DEF = 8;
    localparam int PC_W = $clog2(DEPTH_DEF);
    localparam logic [IW_DEF-1:0] HALT_WORD = 8'hFF;
    localparam int MODE_BIT = 7;
    localparam int OP_MSB = 6;
    localparam int OP_LSB = 4;
    localparam int RD_MSB = 3;
    localparam int RD_LSB = 2;
    localparam int RS_MSB = 1;
    localparam int RS_LSB = 0;
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_ISSUE, S_HALT} state_t;
    function automatic logic is_halt(input logic [IW_DEF-1:0] w);
        return w == HALT_WORD;
    endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: program-load, run/redirect and instruction handshake bus
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IW = IW_DEF
);
    localparam int AW = $clog2(DEPTH);
    logic          load_en;
    logic          load_we;
    logic [AW-1:0] load_addr;
    logic [IW-1:0] load_data;
    logic          run;
    logic          instr_ready;
    logic          jump_en;
    logic [AW-1:0] jump_target;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          halted;
    logic          busy;
    modport master (
        output load_en, load_we, load_addr, load_data, run, instr_ready, jump_en, jump_target,
        input  instr, instr_valid, pc, halted, busy
    );
    modport slave (
        input  load_en, load_we, load_addr, load_data, run, instr_ready, jump_en, jump_target,
        output instr, instr_valid, pc, halted, busy
    );
endinterface

// File: rtl/instr_fetch_unit_prog_mem.sv
// prog_mem: DEPTH x IW program memory, synchronous write and registered read, no reset
module prog_mem #(
    parameter int DEPTH = 16,
    parameter int IW = 8,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [IW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [IW-1:0] o_rdata
);
    logic [IW-1:0] r_mem [DEPTH];
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: loads program memory, then fetches and issues instructions to the control unit
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int IW = IW_DEF
) (
    input logic i_clock,
    input logic i_reset,
    instr_fetch_unit_if.slave io_bus
);
    localparam int AW = $clog2(DEPTH);
    state_t        r_state, w_state_nxt;
    logic [AW-1:0] r_pc, w_pc_nxt;
    logic [IW-1:0] r_instr, w_instr_nxt, w_rdata;
    logic          w_we;
    // Reading at the next pc puts mem[pc] on w_rdata during FETCH, so a halt word never raises instr_valid
    prog_mem #(.DEPTH(DEPTH), .IW(IW)) u_mem (
        .i_clk(i_clock),
        .i_we(w_we),
        .i_waddr(io_bus.load_addr),
        .i_wdata(io_bus.load_data),
        .i_raddr(w_pc_nxt),
        .o_rdata(w_rdata)
    );
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt = r_pc;
        w_instr_nxt = r_instr;
        w_we = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.load_en) w_state_nxt = S_LOAD;
                else if (io_bus.run) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt = '0;
                end
            end
            S_LOAD: begin
                w_we = io_bus.load_we & ~i_reset;
                if (!io_bus.load_en) w_state_nxt = S_IDLE;
            end
            S_FETCH: begin
                if (io_bus.jump_en) w_pc_nxt = io_bus.jump_target;
                else if (is_halt(w_rdata)) w_state_nxt = S_HALT;
                else begin
                    w_state_nxt = S_ISSUE;
                    w_instr_nxt = w_rdata;
                end
            end
            S_ISSUE: begin
                if (io_bus.jump_en) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt = io_bus.jump_target;
                end else if (io_bus.instr_ready) begin
                    w_state_nxt = S_FETCH;
                    w_pc_nxt = r_pc + 1'b1;
                end
            end
            S_HALT: begin
                if (io_bus.load_en) w_state_nxt = S_LOAD;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_pc <= '0;
            r_instr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc <= w_pc_nxt;
            r_instr <= w_instr_nxt;
        end
    end
    assign io_bus.instr = r_instr;
    assign io_bus.instr_valid = r_state == S_ISSUE;
    assign io_bus.pc = r_pc;
    assign io_bus.halted = r_state == S_HALT;
    assign io_bus.busy = r_state == S_FETCH || r_state == S_ISSUE;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed vector table plus hand-written multi-cycle sequences
module tb_instr_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    instr_fetch_unit_if #(.DEPTH(16), .IW(8)) bus ();
    instr_fetch_unit dut (.i_clock(clk), .i_reset(rst), .io_bus(bus));
    typedef struct {
        logic       run;
        logic       ready;
        logic       jump;
        logic [3:0] tgt;
        logic       load;
        logic [14:0] exp;
    } vec_t;
    vec_t vecs [12];
    logic [7:0] prog [16];
    function automatic logic [14:0] e(input logic v, input logic [7:0] i, input logic [3:0] p,
                                      input logic h, input logic b);
        return {v, i, p, h, b};
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [14:0] exp);
        logic [14:0] got;
        got = {bus.instr_valid, bus.instr, bus.pc, bus.halted, bus.busy};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got {valid,instr,pc,halted,busy}=%0b,%h,%0d,%0b,%0b expected %0b,%h,%0d,%0b,%0b",
                     name, got[14], got[13:6], got[5:2], got[1], got[0],
                     exp[14], exp[13:6], exp[5:2], exp[1], exp[0]);
        end
    endtask
    task automatic clr();
        bus.load_en = 0; bus.load_we = 0; bus.load_addr = 0; bus.load_data = 0;
        bus.run = 0; bus.instr_ready = 0; bus.jump_en = 0; bus.jump_target = 0;
    endtask
    task automatic do_reset();
        clr();
        rst = 1;
        tick();
        chk("reset", e(0, 8'h00, 0, 0, 0));
        rst = 0;
    endtask
    // Last word is written in the same cycle load_en drops
    task automatic load_prog(input int n);
        bus.load_en = 1;
        tick();
        for (int i = 0; i < n; i++) begin
            bus.load_en = (i != n - 1);
            bus.load_we = 1;
            bus.load_addr = 4'(i);
            bus.load_data = prog[i];
            tick();
        end
        clr();
    endtask
    initial begin
        vecs[0]  = '{1, 1, 0, 4'd0, 0, e(0, 8'h00, 0, 0, 1)};
        vecs[1]  = '{0, 1, 0, 4'd0, 0, e(1, 8'h30, 0, 0, 1)};
        vecs[2]  = '{0, 1, 0, 4'd0, 0, e(0, 8'h30, 1, 0, 1)};
        vecs[3]  = '{0, 1, 0, 4'd0, 0, e(1, 8'h30, 1, 0, 1)};
        vecs[4]  = '{0, 1, 0, 4'd0, 0, e(0, 8'h30, 2, 0, 1)};
        vecs[5]  = '{0, 1, 0, 4'd0, 0, e(1, 8'h10, 2, 0, 1)};
        vecs[6]  = '{0, 1, 0, 4'd0, 0, e(0, 8'h10, 3, 0, 1)};
        vecs[7]  = '{0, 1, 0, 4'd0, 0, e(0, 8'h10, 3, 1, 0)};
        vecs[8]  = '{1, 1, 1, 4'd5, 0, e(0, 8'h10, 3, 1, 0)};
        vecs[9]  = '{0, 0, 0, 4'd0, 1, e(0, 8'h10, 3, 0, 0)};
        vecs[10] = '{0, 0, 0, 4'd0, 0, e(0, 8'h10, 3, 0, 0)};
        vecs[11] = '{1, 0, 0, 4'd0, 0, e(0, 8'h10, 0, 0, 1)};
        clr();
        tick();
        do_reset();
        prog[0] = 8'h30; prog[1] = 8'h30; prog[2] = 8'h10; prog[3] = 8'hFF;
        load_prog(4);
        for (int i = 0; i < 12; i++) begin
            bus.run = vecs[i].run;
            bus.instr_ready = vecs[i].ready;
            bus.jump_en = vecs[i].jump;
            bus.jump_target = vecs[i].tgt;
            bus.load_en = vecs[i].load;
            tick();
            chk($sformatf("vec%0d", i), vecs[i].exp);
        end
        // ready held low in ISSUE: nothing moves, load_en/run ignored
        do_reset();
        bus.run = 1;
        tick();
        chk("stall_fetch", e(0, 8'h00, 0, 0, 1));
        bus.run = 0;
        tick();
        chk("stall_issue", e(1, 8'h30, 0, 0, 1));
        for (int i = 0; i < 5; i++) begin
            bus.load_en = (i == 1);
            bus.run = (i == 3);
            tick();
            chk($sformatf("stall%0d", i), e(1, 8'h30, 0, 0, 1));
        end
        clr();
        bus.instr_ready = 1;
        tick();
        chk("stall_release", e(0, 8'h30, 1, 0, 1));
        bus.instr_ready = 0;
        tick();
        chk("stall_next", e(1, 8'h30, 1, 0, 1));
        // jump beats a same-cycle handshake
        do_reset();
        bus.run = 1;
        bus.instr_ready = 1;
        tick();
        chk("jmp_fetch", e(0, 8'h00, 0, 0, 1));
        bus.run = 0;
        tick();
        chk("jmp_issue0", e(1, 8'h30, 0, 0, 1));
        bus.jump_en = 1;
        bus.jump_target = 4'd2;
        tick();
        chk("jmp_redirect", e(0, 8'h30, 2, 0, 1));
        clr();
        tick();
        chk("jmp_issue2", e(1, 8'h10, 2, 0, 1));
        // load_en wins over run in IDLE; run ignored in LOAD; jump ignored in IDLE
        do_reset();
        bus.load_en = 1;
        bus.run = 1;
        tick();
        chk("both_load", e(0, 8'h00, 0, 0, 0));
        bus.run = 0;
        bus.load_we = 1;
        bus.load_addr = 4'd0;
        bus.load_data = 8'h20;
        tick();
        chk("load_write", e(0, 8'h00, 0, 0, 0));
        clr();
        bus.run = 1;
        tick();
        chk("load_exit", e(0, 8'h00, 0, 0, 0));
        bus.jump_en = 1;
        bus.jump_target = 4'd7;
        tick();
        chk("idle_jump_ignored", e(0, 8'h00, 0, 0, 1));
        clr();
        tick();
        chk("load_readback", e(1, 8'h20, 0, 0, 1));
        // wrap from 15 to 0 without halting
        do_reset();
        for (int i = 0; i < 16; i++) prog[i] = 8'h30;
        load_prog(16);
        bus.run = 1;
        bus.instr_ready = 1;
        tick();
        chk("wrap_fetch", e(0, 8'h00, 0, 0, 1));
        bus.run = 0;
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("wrap_issue%0d", k), e(1, 8'h30, 4'(k), 0, 1));
            tick();
            chk($sformatf("wrap_fetch%0d", k), e(0, 8'h30, 4'(k + 1), 0, 1));
        end
        tick();
        chk("wrap_reissue0", e(1, 8'h30, 0, 0, 1));
        for (int k = 1; k <= 5; k++) begin
            tick();
            tick();
        end
        chk("at_issue5", e(1, 8'h30, 5, 0, 1));
        // reset mid-handshake, memory survives
        rst = 1;
        tick();
        chk("reset_in_issue", e(0, 8'h00, 0, 0, 0));
        rst = 0;
        clr();
        bus.run = 1;
        tick();
        bus.run = 0;
        tick();
        chk("mem_kept", e(1, 8'h30, 0, 0, 1));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
